// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory loader
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_W          = 16;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and word write port out of the loader
interface imem_loader_if #(
  parameter int ADDR_W = 7,
  parameter int BITS   = 32
);

  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BITS-1:0]   mem_wdata;

  // master: boot source / memory side; slave: the loader
  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - MSB-first 4-byte shift register with byte counter
module byte_packer
  import imem_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clear,
  input  logic            i_shift,
  input  logic [7:0]      i_byte,
  output logic [BITS-1:0] o_word,
  output logic            o_word_full
);

  logic [BITS-1:0] r_word;
  logic [1:0]      r_cnt;

  // Shift each accepted byte in at the bottom so the first byte ends up in [31:24]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_word <= {r_word[BITS-9:0], i_byte};
      r_cnt  <= r_cnt + 2'd1;
    end
  end

  assign o_word      = r_word;
  // High on the shift that completes a word, so the word is whole on the next cycle
  assign o_word_full = i_shift && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time loader packing a length-prefixed byte stream into imem words
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int BITS   = 32,
  parameter int ADDR_W = $clog2(DEPTH * (BITS / 8))
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  localparam int WCNT_W = $clog2(DEPTH + 1);

  loader_state_t     r_state;
  loader_state_t     w_next;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_addr;
  logic [WCNT_W-1:0] r_word_cnt;
  logic [BITS-1:0]   r_wdata_hold;

  logic              w_accept;
  logic              w_start;
  logic              w_shift;
  logic              w_word_full;
  logic              w_last_word;
  logic [LEN_W-1:0]  w_len_full;
  logic [BITS-1:0]   w_word;

  assign bus.byte_ready = (r_state == LEN_HI) || (r_state == LEN_LO) || (r_state == DATA);
  assign w_accept       = bus.byte_valid && bus.byte_ready;
  assign w_start        = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
  assign w_shift        = w_accept && (r_state == DATA);
  // Length check must see the low byte being accepted this cycle
  assign w_len_full     = {r_len[LEN_W-1:8], bus.byte_in};
  assign w_last_word    = (LEN_W'(r_word_cnt) + LEN_W'(1)) == r_len;

  byte_packer #(.BITS(BITS)) u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_start),
    .i_shift     (w_shift),
    .i_byte      (bus.byte_in),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: if (w_start) w_next = LEN_HI;
      LEN_HI:          if (w_accept) w_next = LEN_LO;
      LEN_LO: begin
        if (w_accept) begin
          if (w_len_full == '0)                 w_next = DONE;
          else if (w_len_full > LEN_W'(DEPTH))  w_next = ERR;
          else                                  w_next = DATA;
        end
      end
      DATA:            if (w_word_full) w_next = WRITE;
      WRITE:           w_next = w_last_word ? DONE : DATA;
      default:         w_next = IDLE;
    endcase
  end

  // Length capture, address/word counting and held write data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len        <= '0;
      r_addr       <= '0;
      r_word_cnt   <= '0;
      r_wdata_hold <= '0;
    end else begin
      case (r_state)
        IDLE, DONE, ERR: begin
          if (w_start) begin
            r_len      <= '0;
            r_addr     <= '0;
            r_word_cnt <= '0;
          end
        end
        LEN_HI: if (w_accept) r_len[LEN_W-1:8] <= bus.byte_in;
        LEN_LO: if (w_accept) r_len[7:0]       <= bus.byte_in;
        WRITE: begin
          r_addr       <= r_addr + ADDR_W'(BYTES_PER_WORD);
          r_word_cnt   <= r_word_cnt + WCNT_W'(1);
          r_wdata_hold <= w_word;
        end
        default: ;
      endcase
    end
  end

  // The packer holds the whole word throughout WRITE; afterwards the last written word is held
  assign bus.mem_we    = (r_state == WRITE);
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = (r_state == WRITE) ? w_word : r_wdata_hold;
  assign done          = (r_state == DONE);
  assign error         = (r_state == ERR);
  assign cpu_hold      = (r_state != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  localparam int DEPTH  = 32;
  localparam int BITS   = 32;
  localparam int ADDR_W = 7;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic cpu_hold;
  logic done;
  logic error;

  imem_loader_if #(.ADDR_W(ADDR_W), .BITS(BITS)) bus ();

  imem_loader #(.DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          held_cnt = 0;
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];

  // Record every write strobe, and whether a byte was being held during it
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_a.push_back(32'(bus.mem_addr));
      wr_d.push_back(bus.mem_wdata);
      if (bus.byte_valid) held_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int budget, output bit ok);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.byte_ready) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic put(input logic [7:0] b);
    bit ok;
    send_byte(b, 20, ok);
    check("byte_accept", 32'(ok), 32'd1);
  endtask

  task automatic gap(input int n);
    bus.byte_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear_log();
    wr_a.delete();
    wr_d.delete();
    held_cnt = 0;
  endtask

  function automatic logic [7:0] img_byte(input int i);
    return 8'(i * 37 + 5);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [31:0] exp_w;

    rst_n = 1'b0;
    start = 1'b0;
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;

    // Reset with random inputs
    repeat (4) begin
      start          = 1'($urandom);
      bus.byte_in    = 8'($urandom);
      bus.byte_valid = 1'($urandom);
      tick();
    end
    check("rst_cpu_hold",   32'(cpu_hold),       32'd1);
    check("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_mem_we",     32'(bus.mem_we),     32'd0);
    check("rst_done",       32'(done),           32'd0);
    check("rst_error",      32'(error),          32'd0);
    check("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    start = 1'b0;
    bus.byte_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Two-word load; a start pulse mid-DATA must be ignored
    clear_log();
    pulse_start();
    put(8'h00); put(8'h02); put(8'hDE);
    start = 1'b1;
    put(8'hAD);
    start = 1'b0;
    put(8'hBE); put(8'hEF);
    check("w0_we",   32'(bus.mem_we),   32'd1);
    check("w0_addr", 32'(bus.mem_addr), 32'd0);
    check("w0_data", bus.mem_wdata,     32'hDEADBEEF);
    put(8'h01); put(8'h23); put(8'h45); put(8'h67);
    bus.byte_valid = 1'b0;
    check("w1_we",   32'(bus.mem_we),   32'd1);
    check("w1_addr", 32'(bus.mem_addr), 32'd4);
    check("w1_data", bus.mem_wdata,     32'h01234567);
    check("w1_done_early", 32'(done),   32'd0);
    tick();
    check("two_done",     32'(done),          32'd1);
    check("two_cpu_hold", 32'(cpu_hold),      32'd0);
    check("two_nwrites",  32'(wr_a.size()),   32'd2);
    check("two_hold_data", bus.mem_wdata,     32'h01234567);
    check("two_we_idle",  32'(bus.mem_we),    32'd0);

    // Zero length; start arrives with a byte already valid in DONE
    clear_log();
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b1;
    start = 1'b1;
    check("done_start_ready", 32'(bus.byte_ready), 32'd0);
    tick();
    start = 1'b0;
    check("restart_done_clr", 32'(done),     32'd0);
    check("restart_hold",     32'(cpu_hold), 32'd1);
    put(8'h00); put(8'h00);
    bus.byte_valid = 1'b0;
    check("zero_done",    32'(done),         32'd1);
    check("zero_nwrites", 32'(wr_a.size()),  32'd0);
    send_byte(8'h99, 5, ok);
    bus.byte_valid = 1'b0;
    check("zero_extra_rejected", 32'(ok),    32'd0);
    check("zero_still_done",     32'(done),  32'd1);

    // Oversize length, then recovery
    clear_log();
    pulse_start();
    put(8'h00); put(8'h21);
    bus.byte_valid = 1'b0;
    check("ovr_error",    32'(error),    32'd1);
    check("ovr_cpu_hold", 32'(cpu_hold), 32'd1);
    check("ovr_done",     32'(done),     32'd0);
    repeat (3) tick();
    check("ovr_sticky",   32'(error),        32'd1);
    check("ovr_nwrites",  32'(wr_a.size()),  32'd0);
    pulse_start();
    check("rec_error_clr", 32'(error), 32'd0);
    put(8'h00); put(8'h01);
    put(8'hAA); put(8'hBB); put(8'hCC); put(8'hDD);
    bus.byte_valid = 1'b0;
    check("rec_we",   32'(bus.mem_we),   32'd1);
    check("rec_addr", 32'(bus.mem_addr), 32'd0);
    check("rec_data", bus.mem_wdata,     32'hAABBCCDD);
    tick();
    check("rec_done",    32'(done),         32'd1);
    check("rec_nwrites", 32'(wr_a.size()),  32'd1);

    // Full image with gaps; first byte of each word is held through WRITE
    clear_log();
    pulse_start();
    put(8'h00); put(8'h20);
    for (int i = 0; i < DEPTH * 4; i++) begin
      if ((i % 4) != 0) gap($urandom_range(0, 2));
      put(img_byte(i));
    end
    bus.byte_valid = 1'b0;
    tick();
    check("full_done",     32'(done),         32'd1);
    check("full_nwrites",  32'(wr_a.size()),  32'd32);
    check("full_held",     32'(held_cnt),     32'd31);
    for (int k = 0; k < DEPTH && k < wr_a.size(); k++) begin
      exp_w = {img_byte(4*k), img_byte(4*k+1), img_byte(4*k+2), img_byte(4*k+3)};
      check($sformatf("full_addr%0d", k), wr_a[k], 32'(4 * k));
      check($sformatf("full_data%0d", k), wr_d[k], exp_w);
    end

    // Reset in the middle of a word, then a clean load
    clear_log();
    pulse_start();
    put(8'h00); put(8'h01); put(8'hDE); put(8'hAD);
    bus.byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready",    32'(bus.byte_ready), 32'd0);
    check("mid_rst_hold",     32'(cpu_hold),       32'd1);
    check("mid_rst_we",       32'(bus.mem_we),     32'd0);
    check("mid_rst_addr",     32'(bus.mem_addr),   32'd0);
    check("mid_rst_wdata",    bus.mem_wdata,       32'd0);
    check("mid_rst_done",     32'(done),           32'd0);
    check("mid_rst_error",    32'(error),          32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rst_nwrites", 32'(wr_a.size()), 32'd0);
    pulse_start();
    put(8'h00); put(8'h01);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    bus.byte_valid = 1'b0;
    check("fresh_we",   32'(bus.mem_we),   32'd1);
    check("fresh_addr", 32'(bus.mem_addr), 32'd0);
    check("fresh_data", bus.mem_wdata,     32'h11223344);
    tick();
    check("fresh_done",    32'(done),        32'd1);
    check("fresh_nwrites", 32'(wr_a.size()), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the byte-addressed instruction memory.
- Accepts a length-prefixed byte stream over a valid/ready handshake and packs each group of 4 bytes into a word, MSB first.
- Issues one word write per 4 bytes to the memory write port, starting at byte address 0.
- Holds the CPU pipeline in reset (cpu_hold) until the image is fully loaded.

Parameters:
- DEPTH, 32: number of BITS-wide words in instruction memory.
- BITS, 32: word width. Must be 32; byte-lane packing assumes 4 bytes per word.
- ADDR_W, $clog2(DEPTH*(BITS/8)): byte-address width. Derived; not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERR.
- byte_in  input  8  stream data.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  word write strobe to instruction memory.
- mem_addr  output  ADDR_W  word-aligned byte address; bits [1:0] always 0.
- mem_wdata  output  BITS  packed word. Memory stores mem[a]=[31:24], mem[a+1]=[23:16], mem[a+2]=[15:8], mem[a+3]=[7:0].
- cpu_hold  output  1  keeps the CPU in reset.
- done  output  1  load completed successfully.
- error  output  1  declared length exceeds DEPTH.

Behaviour:
- Reset is asynchronous, active-low: one clock, reset asserted when rst_n=0.
- Reset values:
  - state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, error=0, cpu_hold=1.
  - Internal length, word counter and byte counter all cleared.
- Handshake:
  - A byte is accepted on a rising edge where byte_valid && byte_ready.
  - byte_ready is combinational from state: 1 in LEN_HI, LEN_LO and DATA; 0 otherwise.
  - A producer may hold byte_valid across byte_ready=0 cycles. Data is not consumed until accepted.
- States:
  - IDLE: on start, clear addr and counters, deassert done/error, set cpu_hold=1 -> LEN_HI.
  - LEN_HI: accept byte -> len[15:8], go to LEN_LO.
  - LEN_LO: accept byte -> len[7:0]. Then:
    - if len==0 -> DONE;
    - else if len>DEPTH -> ERR;
    - else -> DATA.
    - The len comparison uses the full 16-bit value, including the byte just accepted.
  - DATA: each accepted byte shifts into the word register MSB-first and byte_cnt increments (2 bits). The 4th accepted byte goes to WRITE.
  - WRITE: exactly one cycle.
    - mem_we=1 with the current mem_addr and the full packed word.
    - Next edge: mem_addr += 4, word_cnt += 1.
    - If word_cnt+1 == len -> DONE, else -> DATA.
  - DONE: done=1, cpu_hold=0. Sticky until start or reset.
  - ERR: error=1, cpu_hold=1. No memory writes occur. Sticky until start or reset.
- Latency: mem_we asserts exactly 1 cycle after the 4th byte of a word is accepted. done asserts 1 cycle after the final WRITE cycle.
- mem_we is 0 in every state except WRITE.
- mem_wdata holds its last value outside WRITE.
- Widths:
  - word_cnt is $clog2(DEPTH+1) bits.
  - mem_addr wraps modulo 2^ADDR_W, but the len<=DEPTH check prevents wrap.
  - The final write for len=DEPTH is at address 4*(DEPTH-1).
- Boundary cases:
  - start outside IDLE/DONE/ERR is ignored.
  - start in the same cycle as a byte_valid in DONE: the byte is not accepted (byte_ready=0).
  - Extra bytes after DONE are never accepted.
  - rst_n deasserted mid-word discards any partial word and returns all outputs to their reset values.

Decomposition:
- Shared package imem_pkg holds:
  - the state enum loader_state_t {IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR};
  - constants BYTES_PER_WORD=4 and LEN_W=16.
- One natural sub-module, byte_packer: a 4-byte MSB-first shift register with a byte counter and a word_full flag. The FSM, address and word counter stay in imem_loader.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> cpu_hold=1, byte_ready=0, mem_we=0, done=0, error=0, mem_addr=0.
- Two-word load: start, then stream 00 02 DE AD BE EF 01 23 45 67 -> mem_we pulses at addr 0 with DEADBEEF, then at addr 4 with 01234567. Then done=1, cpu_hold=0, exactly 2 write strobes.
- Zero length: stream 00 00 -> DONE 1 cycle after the second byte, no mem_we, a third byte is never accepted.
- Oversize: stream 00 21 (33 with DEPTH=32) -> error=1, cpu_hold=1, no mem_we. A later start plus 00 01 AA BB CC DD -> error=0, write AABBCCDD at addr 0, done=1.
- Full image with backpressure: len=32, random byte_valid gaps, one byte held valid during each WRITE cycle -> held byte accepted the cycle after WRITE, 32 writes, last at addr 124, data matches the stream.
- Reset mid-operation: drop rst_n after 2 of 4 data bytes -> immediate reset values, no write. A fresh load writes word 0 at addr 0 with no residue from the partial word.
